// File: rtl/wb_scoreboard_arbiter.sv
// Register scoreboard plus round-robin writeback arbiter in front of a shared
// GPR/FPR register-file write port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ptr      | requester searched first in the next arbitration (0..2)
// busy     | per-register pending-write flag, GPR 0 never set
// out reg  | grant captured at the end of cycle T, driven during T+1
module wb_scoreboard_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int NREQ   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [1:0]               iss_rs_file,
  input  logic [REG_W-1:0]         iss_rs,
  input  logic [1:0]               iss_rt_file,
  input  logic [REG_W-1:0]         iss_rt,
  input  logic [1:0]               iss_rd_file,
  input  logic [REG_W-1:0]         iss_rd,
  input  logic [NREQ-1:0]          wb_valid,
  input  logic [2*NREQ-1:0]        wb_file,
  input  logic [REG_W*NREQ-1:0]    wb_dst,
  input  logic [DATA_W*NREQ-1:0]   wb_data,
  output logic [NREQ-1:0]          wb_ready,
  output logic [1:0]               regwrite,
  output logic [REG_W-1:0]         regdst,
  output logic [DATA_W-1:0]        dtowrite,
  output logic [(1<<REG_W)-1:0]    gpr_busy,
  output logic [(1<<REG_W)-1:0]    fpr_busy,
  output logic                     wb_err
);

  localparam int NREG = 1 << REG_W;
  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_GPR  = 2'b01;
  localparam logic [1:0] F_FPR  = 2'b10;

  logic [1:0]        ptr;
  logic [1:0]        ptr_nxt;
  logic              grant_any;
  logic [1:0]        gsel;
  logic [1:0]        sel_file;
  logic [REG_W-1:0]  sel_dst;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        eff_file;
  logic [NREG-1:0]   gpr_nxt;
  logic [NREG-1:0]   fpr_nxt;
  logic              err_nxt;

  function automatic logic reg_hit(input logic [1:0] f, input logic [REG_W-1:0] r,
                                   input logic [NREG-1:0] gb, input logic [NREG-1:0] fb);
    return (f == F_GPR && r != '0 && gb[r]) || (f == F_FPR && fb[r]);
  endfunction

  // No bypass: a register clearing this cycle still stalls, so only the
  // registered busy bits feed the hazard check.
  assign iss_ready = !(reg_hit(iss_rs_file, iss_rs, gpr_busy, fpr_busy) |
                       reg_hit(iss_rt_file, iss_rt, gpr_busy, fpr_busy) |
                       reg_hit(iss_rd_file, iss_rd, gpr_busy, fpr_busy));

  // Round-robin search starting at ptr; grant depends on valid and ptr only.
  always_comb begin
    int idx;
    idx       = 0;
    wb_ready  = '0;
    grant_any = 1'b0;
    gsel      = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && wb_valid[idx]) begin
        wb_ready[idx] = 1'b1;
        grant_any     = 1'b1;
        gsel          = 2'(idx);
      end
    end
  end

  // Pick the granted request's fields; file 11 or GPR 0 consume the grant
  // but never write.
  always_comb begin
    sel_file = wb_file[2*int'(gsel) +: 2];
    sel_dst  = wb_dst[REG_W*int'(gsel) +: REG_W];
    sel_data = wb_data[DATA_W*int'(gsel) +: DATA_W];
    eff_file = F_NONE;
    if (grant_any && ((sel_file == F_GPR && sel_dst != '0) || sel_file == F_FPR))
      eff_file = sel_file;
    ptr_nxt = ptr;
    if (grant_any) ptr_nxt = (gsel == 2'(NREQ-1)) ? 2'd0 : gsel + 2'd1;
  end

  // Busy update: clear on the register-file write edge, then set for the
  // issuing destination (WAW stall keeps the two from colliding).
  always_comb begin
    gpr_nxt = gpr_busy;
    fpr_nxt = fpr_busy;
    err_nxt = wb_err;
    case (regwrite)
      F_GPR: begin
        if (!gpr_busy[regdst]) err_nxt = 1'b1;
        gpr_nxt[regdst] = 1'b0;
      end
      F_FPR: begin
        if (!fpr_busy[regdst]) err_nxt = 1'b1;
        fpr_nxt[regdst] = 1'b0;
      end
      default: ;
    endcase
    if (iss_valid && iss_ready) begin
      if (iss_rd_file == F_GPR && iss_rd != '0) gpr_nxt[iss_rd] = 1'b1;
      else if (iss_rd_file == F_FPR)            fpr_nxt[iss_rd] = 1'b1;
    end
  end

  // State registers: pointer, output stage, scoreboard, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 2'd0;
      regwrite <= F_NONE;
      regdst   <= '0;
      dtowrite <= '0;
      gpr_busy <= '0;
      fpr_busy <= '0;
      wb_err   <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      regwrite <= eff_file;
      if (grant_any) begin
        regdst   <= sel_dst;
        dtowrite <= sel_data;
      end
      gpr_busy <= gpr_nxt;
      fpr_busy <= fpr_nxt;
      wb_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Bench for wb_scoreboard_arbiter: directed sequences, a hazard table and a
// randomized run against a register-level reference model.
module tb_wb_scoreboard_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [1:0]  iss_rs_file = '0, iss_rt_file = '0, iss_rd_file = '0;
  logic [4:0]  iss_rs = '0, iss_rt = '0, iss_rd = '0;
  logic [2:0]  wb_valid = '0;
  logic [5:0]  wb_file = '0;
  logic [14:0] wb_dst = '0;
  logic [95:0] wb_data = '0;
  logic [2:0]  wb_ready;
  logic [1:0]  regwrite;
  logic [4:0]  regdst;
  logic [31:0] dtowrite;
  logic [31:0] gpr_busy, fpr_busy;
  logic        wb_err;

  wb_scoreboard_arbiter dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs_file(iss_rs_file), .iss_rs(iss_rs),
    .iss_rt_file(iss_rt_file), .iss_rt(iss_rt),
    .iss_rd_file(iss_rd_file), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_file(wb_file), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_ready(wb_ready), .regwrite(regwrite), .regdst(regdst), .dtowrite(dtowrite),
    .gpr_busy(gpr_busy), .fpr_busy(fpr_busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_iss(input logic v, input logic [1:0] rsf, input logic [4:0] rs,
                         input logic [1:0] rtf, input logic [4:0] rt,
                         input logic [1:0] rdf, input logic [4:0] rd);
    iss_valid = v; iss_rs_file = rsf; iss_rs = rs;
    iss_rt_file = rtf; iss_rt = rt; iss_rd_file = rdf; iss_rd = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wb_valid = '0; iss_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] rsf; logic [4:0] rs;
    logic [1:0] rtf; logic [4:0] rt;
    logic [1:0] rdf; logic [4:0] rd;
    logic       exp;
  } hz_t;
  hz_t tbl[10];

  // reference model: busy sets, requester queue, expected output stage
  logic [31:0] m_gb, m_fb;
  int          m_ptr;
  logic [1:0]  m_out_f;
  logic [4:0]  m_out_d;
  logic [31:0] m_out_data;
  logic        m_err;
  logic        rq_v[3];
  logic [1:0]  rq_f[3];
  logic [4:0]  rq_d[3];
  logic [31:0] rq_data[3];

  function automatic bit mhit(input logic [1:0] f, input logic [4:0] r);
    return (f == 2'b01 && r != 0 && m_gb[r]) || (f == 2'b10 && m_fb[r]);
  endfunction

  // a requester may only target a register that is busy and not already
  // owed a write by another requester or the output stage
  function automatic bit claimable(input logic [1:0] f, input logic [4:0] d);
    bit ok;
    ok = (f == 2'b01) ? (d != 0 && m_gb[d]) : m_fb[d];
    if (m_out_f == f && m_out_d == d) ok = 0;
    for (int i = 0; i < 3; i++) if (rq_v[i] && rq_f[i] == f && rq_d[i] == d) ok = 0;
    return ok;
  endfunction

  task automatic drive_wb();
    for (int i = 0; i < 3; i++) begin
      wb_valid[i]         = rq_v[i];
      wb_file[2*i +: 2]   = rq_v[i] ? rq_f[i] : 2'b00;
      wb_dst[5*i +: 5]    = rq_d[i];
      wb_data[32*i +: 32] = rq_data[i];
    end
  endtask

  initial begin
    logic [2:0]  vm, eg;
    logic [1:0]  cf, ef;
    logic [4:0]  cd;
    logic        er;
    int          g, idx;

    tbl[0] = '{2'b01, 5'd5, 2'b00, 5'd0, 2'b00, 5'd0, 1'b0};
    tbl[1] = '{2'b10, 5'd5, 2'b00, 5'd0, 2'b00, 5'd0, 1'b1};
    tbl[2] = '{2'b00, 5'd5, 2'b00, 5'd0, 2'b00, 5'd0, 1'b1};
    tbl[3] = '{2'b11, 5'd5, 2'b11, 5'd7, 2'b11, 5'd5, 1'b1};
    tbl[4] = '{2'b00, 5'd0, 2'b10, 5'd7, 2'b00, 5'd0, 1'b0};
    tbl[5] = '{2'b00, 5'd0, 2'b00, 5'd0, 2'b10, 5'd7, 1'b0};
    tbl[6] = '{2'b00, 5'd0, 2'b00, 5'd0, 2'b01, 5'd7, 1'b1};
    tbl[7] = '{2'b01, 5'd0, 2'b01, 5'd0, 2'b01, 5'd0, 1'b1};
    tbl[8] = '{2'b01, 5'd6, 2'b01, 5'd4, 2'b01, 5'd3, 1'b1};
    tbl[9] = '{2'b00, 5'd0, 2'b01, 5'd5, 2'b10, 5'd6, 1'b0};

    // reset then idle
    do_reset();
    set_iss(1'b0, 2'b01, 5'd3, 2'b01, 5'd4, 2'b01, 5'd5);
    #1;
    chk("reset_regwrite", regwrite, 2'b00);
    chk("reset_gpr_busy", gpr_busy, 0);
    chk("reset_fpr_busy", fpr_busy, 0);
    chk("reset_wb_err", wb_err, 0);
    chk("reset_iss_ready", iss_ready, 1);

    // RAW stall and ALU writeback
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b01, 5'd5); #1;
    chk("raw_t0_ready", iss_ready, 1);
    @(negedge clk); set_iss(1'b1, 2'b01, 5'd5, 2'b00, 5'd0, 2'b00, 5'd0); #1;
    chk("raw_t1_ready", iss_ready, 0);
    chk("raw_t1_busy", gpr_busy, 32'h20);
    @(negedge clk); #1;
    chk("raw_t2_ready", iss_ready, 0);
    @(negedge clk);
    wb_valid = 3'b001; wb_file[1:0] = 2'b01; wb_dst[4:0] = 5'd5; wb_data[31:0] = 32'hDEADBEEF; #1;
    chk("raw_t3_grant", wb_ready, 3'b001);
    chk("raw_t3_ready", iss_ready, 0);
    @(negedge clk); wb_valid = '0; #1;
    chk("raw_t4_regwrite", regwrite, 2'b01);
    chk("raw_t4_regdst", regdst, 5'd5);
    chk("raw_t4_data", dtowrite, 32'hDEADBEEF);
    chk("raw_t4_ready", iss_ready, 0);
    @(negedge clk); #1;
    chk("raw_t5_ready", iss_ready, 1);
    chk("raw_t5_busy", gpr_busy, 0);

    // hazard table: GPR5 and FPR7 busy
    do_reset();
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b01, 5'd5);
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b10, 5'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_iss(1'b0, tbl[i].rsf, tbl[i].rs, tbl[i].rtf, tbl[i].rt, tbl[i].rdf, tbl[i].rd);
      #1;
      chk($sformatf("hazard_tbl_%0d", i), iss_ready, tbl[i].exp);
    end

    // round-robin with all three requesters
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b10, 5'(k));
    end
    @(negedge clk);
    iss_valid = 1'b0;
    wb_file = 6'b101010; wb_dst = {5'd3, 5'd2, 5'd1};
    wb_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      vm = 3'b111; vm = vm << k; wb_valid = vm;
      #1;
      eg = 3'b001; eg = eg << k;
      chk($sformatf("rr_grant_%0d", k), wb_ready, eg);
      if (k > 0) begin
        chk($sformatf("rr_regwrite_%0d", k), regwrite, 2'b10);
        chk($sformatf("rr_regdst_%0d", k), regdst, 5'(k));
        chk($sformatf("rr_data_%0d", k), dtowrite, 32'hA000_0000 + 32'(k));
      end
    end
    @(negedge clk); wb_valid = '0; #1;
    chk("rr_regwrite_3", regwrite, 2'b10);
    chk("rr_regdst_3", regdst, 5'd3);
    chk("rr_data_3", dtowrite, 32'hA000_0003);
    @(negedge clk); #1;
    chk("rr_fpr_clear", fpr_busy, 0);
    chk("rr_regwrite_idle", regwrite, 2'b00);

    // WAW stall and GPR0 destination
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b10, 5'd7); #1;
    chk("waw_first_ready", iss_ready, 1);
    @(negedge clk); #1;
    chk("waw_second_ready", iss_ready, 0);
    chk("waw_fpr_busy", fpr_busy, 32'h80);
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b01, 5'd0); #1;
    chk("gpr0_first_ready", iss_ready, 1);
    @(negedge clk); #1;
    chk("gpr0_second_ready", iss_ready, 1);
    @(negedge clk); iss_valid = 1'b0; #1;
    chk("gpr0_busy", gpr_busy, 0);

    // spurious FPU writeback to a free GPR9
    @(negedge clk);
    wb_valid = 3'b100; wb_file[5:4] = 2'b01; wb_dst[14:10] = 5'd9; wb_data[95:64] = 32'h0000_9999; #1;
    chk("spur_grant", wb_ready, 3'b100);
    @(negedge clk); wb_valid = '0; #1;
    chk("spur_regwrite", regwrite, 2'b01);
    chk("spur_regdst", regdst, 5'd9);
    chk("spur_err_t1", wb_err, 0);
    @(negedge clk); #1;
    chk("spur_err_t2", wb_err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("spur_err_sticky", wb_err, 1);
    do_reset(); #1;
    chk("spur_err_reset", wb_err, 0);

    // reset in the middle of a grant
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b01, 5'd2);
    @(negedge clk); set_iss(1'b1, 2'b00, 5'd0, 2'b00, 5'd0, 2'b10, 5'd4);
    @(negedge clk);
    iss_valid = 1'b0;
    wb_valid = 3'b010; wb_file = 6'b000100; wb_dst = {5'd0, 5'd2, 5'd0}; #1;
    chk("mid_grant", wb_ready, 3'b010);
    chk("mid_busy", {gpr_busy, fpr_busy}, {32'h4, 32'h10});
    @(negedge clk); rst = 1'b1; wb_valid = '0;
    @(negedge clk); rst = 1'b0; wb_file = '0; wb_valid = 3'b111; #1;
    chk("mid_regwrite", regwrite, 2'b00);
    chk("mid_gpr_busy", gpr_busy, 0);
    chk("mid_fpr_busy", fpr_busy, 0);
    chk("mid_ptr_restart", wb_ready, 3'b001);

    // randomized run against the reference model
    do_reset();
    m_gb = '0; m_fb = '0; m_ptr = 0; m_out_f = 2'b00; m_out_d = '0; m_out_data = '0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin rq_v[i] = 0; rq_f[i] = 0; rq_d[i] = 0; rq_data[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rq_v[i] && $urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 15) == 0) begin
            rq_v[i] = 1'b1;
            rq_f[i] = $urandom_range(0, 1) ? 2'b11 : 2'b01;
            rq_d[i] = (rq_f[i] == 2'b11) ? 5'($urandom_range(0, 31)) : 5'd0;
            rq_data[i] = $urandom;
          end else begin
            cf = 2'($urandom_range(1, 2));
            cd = 5'($urandom_range(0, 7));
            if (claimable(cf, cd)) begin
              rq_v[i] = 1'b1; rq_f[i] = cf; rq_d[i] = cd; rq_data[i] = $urandom;
            end
          end
        end
      end
      drive_wb();
      set_iss(1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
      #1;
      er = !(mhit(iss_rs_file, iss_rs) || mhit(iss_rt_file, iss_rt) || mhit(iss_rd_file, iss_rd));
      g = -1;
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (g < 0 && rq_v[idx]) g = idx;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("rnd_iss_ready", iss_ready, er);
      chk("rnd_wb_ready", wb_ready, eg);
      chk("rnd_regwrite", regwrite, m_out_f);
      if (m_out_f != 2'b00) begin
        chk("rnd_regdst", regdst, m_out_d);
        chk("rnd_dtowrite", dtowrite, m_out_data);
      end
      chk("rnd_gpr_busy", gpr_busy, m_gb);
      chk("rnd_fpr_busy", fpr_busy, m_fb);
      chk("rnd_wb_err", wb_err, m_err);
      // advance the model across the coming edge
      if (m_out_f == 2'b01) begin
        if (!m_gb[m_out_d]) m_err = 1'b1;
        m_gb[m_out_d] = 1'b0;
      end else if (m_out_f == 2'b10) begin
        if (!m_fb[m_out_d]) m_err = 1'b1;
        m_fb[m_out_d] = 1'b0;
      end
      m_out_f = 2'b00;
      if (g >= 0) begin
        ef = rq_f[g];
        if ((ef == 2'b01 && rq_d[g] != 0) || ef == 2'b10) m_out_f = ef;
        m_out_d = rq_d[g];
        m_out_data = rq_data[g];
        rq_v[g] = 1'b0;
        m_ptr = (g + 1) % 3;
      end
      if (iss_valid && er) begin
        if (iss_rd_file == 2'b01 && iss_rd != 0) m_gb[iss_rd] = 1'b1;
        else if (iss_rd_file == 2'b10) m_fb[iss_rd] = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
